// File: rtl/sort_dedup.sv
// Adjacent-duplicate filter for sorted Avalon-ST packets.
// Re-frames sop/eop on the reduced packet and pulses per-packet stats.
module sort_dedup #(
    parameter  int DWIDTH      = 8,
    parameter  int MAX_PKT_LEN = 16,
    localparam int CWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              stat_valid_o,
    output logic [CWIDTH-1:0] stat_uniq_o,
    output logic [CWIDTH-1:0] stat_dup_o
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HOLD,
        S_LAST
    } state_t;

    state_t state_q, state_d;

    logic [DWIDTH-1:0] held_q, held_d;
    logic              held_sop_q, held_sop_d;
    logic [CWIDTH-1:0] uc_q, uc_d;
    logic [CWIDTH-1:0] dc_q, dc_d;

    logic [DWIDTH-1:0] src_data_d;
    logic              src_sop_d;
    logic              src_eop_d;
    logic              src_valid_d;
    logic              stat_valid_d;
    logic [CWIDTH-1:0] stat_uniq_d;
    logic [CWIDTH-1:0] stat_dup_d;

    logic out_free;
    logic accept;

    // sop on the input is not trusted: position in the FSM decides framing
    assign out_free = !src_valid_o || src_ready_i;
    assign accept   = snk_valid_i && snk_ready_o;

    always_comb begin
        snk_ready_o = 1'b0;
        unique case (state_q)
            S_EMPTY: snk_ready_o = 1'b1;
            S_HOLD:  snk_ready_o = out_free;
            S_LAST:  snk_ready_o = 1'b0;
            default: snk_ready_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        held_sop_d   = held_sop_q;
        uc_d         = uc_q;
        dc_d         = dc_q;
        src_data_d   = src_data_o;
        src_sop_d    = src_startofpacket_o;
        src_eop_d    = src_endofpacket_o;
        src_valid_d  = out_free ? 1'b0 : src_valid_o;
        stat_valid_d = 1'b0;
        stat_uniq_d  = stat_uniq_o;
        stat_dup_d   = stat_dup_o;

        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    held_d     = snk_data_i;
                    held_sop_d = 1'b1;
                    uc_d       = '0;
                    dc_d       = '0;
                    state_d    = snk_endofpacket_i ? S_LAST : S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    if (snk_data_i == held_q) begin
                        dc_d = dc_q + CWIDTH'(1);
                    end else begin
                        src_valid_d = 1'b1;
                        src_data_d  = held_q;
                        src_sop_d   = held_sop_q;
                        src_eop_d   = 1'b0;
                        uc_d        = uc_q + CWIDTH'(1);
                        held_d      = snk_data_i;
                        held_sop_d  = 1'b0;
                    end
                    if (snk_endofpacket_i) state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (out_free) begin
                    src_valid_d  = 1'b1;
                    src_data_d   = held_q;
                    src_sop_d    = held_sop_q;
                    src_eop_d    = 1'b1;
                    stat_valid_d = 1'b1;
                    stat_uniq_d  = uc_q + CWIDTH'(1);
                    stat_dup_d   = dc_q;
                    state_d      = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q             <= S_EMPTY;
            held_q              <= '0;
            held_sop_q          <= 1'b0;
            uc_q                <= '0;
            dc_q                <= '0;
            src_data_o          <= '0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_valid_o         <= 1'b0;
            stat_valid_o        <= 1'b0;
            stat_uniq_o         <= '0;
            stat_dup_o          <= '0;
        end else begin
            state_q             <= state_d;
            held_q              <= held_d;
            held_sop_q          <= held_sop_d;
            uc_q                <= uc_d;
            dc_q                <= dc_d;
            src_data_o          <= src_data_d;
            src_startofpacket_o <= src_sop_d;
            src_endofpacket_o   <= src_eop_d;
            src_valid_o         <= src_valid_d;
            stat_valid_o        <= stat_valid_d;
            stat_uniq_o         <= stat_uniq_d;
            stat_dup_o          <= stat_dup_d;
        end
    end

endmodule

// File: tb/tb_sort_dedup.sv
// Bench for sort_dedup: directed packets, queue scoreboard for words
// and stats, stall-stability and asynchronous-reset checks.
module tb_sort_dedup;

    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] snk_data_i = '0;
    logic          snk_startofpacket_i = 1'b0;
    logic          snk_endofpacket_i = 1'b0;
    logic          snk_valid_i = 1'b0;
    logic          snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o;
    logic          src_endofpacket_o;
    logic          src_valid_o;
    logic          src_ready_i = 1'b1;
    logic          stat_valid_o;
    logic [CW-1:0] stat_uniq_o;
    logic [CW-1:0] stat_dup_o;

    sort_dedup #(.DWIDTH(DW), .MAX_PKT_LEN(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .snk_data_i         (snk_data_i),
        .snk_startofpacket_i(snk_startofpacket_i),
        .snk_endofpacket_i  (snk_endofpacket_i),
        .snk_valid_i        (snk_valid_i),
        .snk_ready_o        (snk_ready_o),
        .src_data_o         (src_data_o),
        .src_startofpacket_o(src_startofpacket_o),
        .src_endofpacket_o  (src_endofpacket_o),
        .src_valid_o        (src_valid_o),
        .src_ready_i        (src_ready_i),
        .stat_valid_o       (stat_valid_o),
        .stat_uniq_o        (stat_uniq_o),
        .stat_dup_o         (stat_dup_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_ready = 1'b0;
    bit rand_valid = 1'b0;

    logic [9:0]      exp_q[$];
    logic [2*CW-1:0] stat_q[$];
    logic [DW-1:0]   pkt[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            src_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit            stalled = 1'b0;
    logic [9:0]    stall_val;
    logic [9:0]    obs_w;
    logic [9:0]    exp_w;
    logic [2*CW-1:0] exp_s;

    always @(negedge clk) begin
        if (!rst_i) begin
            obs_w = {src_startofpacket_o, src_endofpacket_o, src_data_o};
            if (stalled) begin
                chk("stall_valid", 32'(src_valid_o), 32'd1);
                chk("stall_hold", 32'(obs_w), 32'(stall_val));
            end
            stalled   = src_valid_o && !src_ready_i;
            stall_val = obs_w;
            if (src_valid_o && src_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(obs_w), 32'h3ff);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("word", 32'(obs_w), 32'(exp_w));
                end
            end
            if (stat_valid_o) begin
                if (stat_q.size() == 0) begin
                    chk("unexpected_stat", 32'({stat_uniq_o, stat_dup_o}),
                        32'h3ff);
                end else begin
                    exp_s = stat_q.pop_front();
                    chk("stat", 32'({stat_uniq_o, stat_dup_o}), 32'(exp_s));
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic s,
                             input logic e);
        bit ok = 1'b0;
        snk_data_i          = d;
        snk_startofpacket_i = s;
        snk_endofpacket_i   = e;
        snk_valid_i         = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ok = snk_ready_o;
            @(posedge clk);
            if (ok) break;
        end
        #1;
        snk_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Reference: keep a word only when it differs from its predecessor.
    task automatic send_pkt();
        int n = pkt.size();
        int nu = 0;
        logic [DW-1:0] u[$];
        for (int i = 0; i < n; i++)
            if (i == 0 || pkt[i] != pkt[i-1]) u.push_back(pkt[i]);
        nu = u.size();
        for (int i = 0; i < nu; i++)
            exp_q.push_back({i == 0, i == nu - 1, u[i]});
        stat_q.push_back({CW'(nu), CW'(n - nu)});
        for (int i = 0; i < n; i++) begin
            while (rand_valid && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send_word(pkt[i], i == 0, i == n - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain_words", 32'(exp_q.size()), 32'd0);
        chk("drain_stats", 32'(stat_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_valid", 32'(src_valid_o), 32'd0);
        chk("rst_src_data", 32'(src_data_o), 32'd0);
        chk("rst_src_sop_eop", 32'({src_startofpacket_o, src_endofpacket_o}), 32'd0);
        chk("rst_stat", 32'({stat_valid_o, stat_uniq_o, stat_dup_o}), 32'd0);
        chk("rst_ready", 32'(snk_ready_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        pkt = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4};
        send_pkt();
        drain();

        pkt = '{8'd5, 8'd5, 8'd5, 8'd5};
        send_pkt();
        drain();

        pkt = '{8'd7};
        send_pkt();
        chk("single_bubble", 32'(snk_ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("single_ready_back", 32'(snk_ready_o), 32'd1);
        drain();

        rand_ready = 1'b1;
        rand_valid = 1'b1;
        pkt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_pkt();
        drain();
        rand_valid = 1'b0;
        pkt = '{8'd2, 8'd2, 8'd3, 8'd8, 8'd8, 8'd9};
        send_pkt();
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        pkt = '{8'd1, 8'd9};
        send_pkt();
        pkt = '{8'd9, 8'd9};
        send_pkt();
        drain();

        exp_q.push_back({1'b1, 1'b0, 8'd1});
        send_word(8'd1, 1'b1, 1'b0);
        send_word(8'd2, 1'b0, 1'b0);
        send_word(8'd3, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(src_valid_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(src_valid_o), 32'd0);
        chk("async_rst_data", 32'(src_data_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("words_before_rst", 32'(exp_q.size()), 32'd0);
        pkt = '{8'd4, 8'd4, 8'd6};
        send_pkt();
        drain();

        repeat (5) @(posedge clk);
        chk("no_stray_words", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
